// File: rtl/score_sched_if.sv
// score_sched_if: request/grant, score and BCD display bundle for score_sched.
// master = requester/display side, slave = score_sched.
interface score_sched_if #(
   parameter int unsigned PTS_W = 4
);
   logic             req_a;
   logic             req_b;
   logic [PTS_W-1:0] pts_a;
   logic [PTS_W-1:0] pts_b;
   logic             clear_score;
   logic             gnt_a;
   logic             gnt_b;
   logic [13:0]      score;
   logic [3:0]       digit0;
   logic [3:0]       digit1;
   logic [3:0]       digit2;
   logic [3:0]       digit3;
   logic             bcd_valid;
   logic             busy;

   modport master (
      output req_a, req_b, pts_a, pts_b, clear_score,
      input  gnt_a, gnt_b, score, digit0, digit1, digit2, digit3, bcd_valid, busy
   );

   modport slave (
      input  req_a, req_b, pts_a, pts_b, clear_score,
      output gnt_a, gnt_b, score, digit0, digit1, digit2, digit3, bcd_valid, busy
   );
endinterface

// File: rtl/score_sched.sv
// score_sched: round-robin arbiter for two score-update requesters, saturating
// score accumulator and serial (shift-add-3) binary-to-BCD converter.
// Optional build macro: SCORE_SCHED_BLANK_EN -- blank leading-zero digits
// (digit3..digit1) as 4'hF; digit0 is always shown.
module score_sched #(
   parameter int unsigned MAX_SCORE = 9999,
   parameter int unsigned PTS_W     = 4
) (
   input  logic         segclk,
   input  logic         clr,
   score_sched_if.slave bus
);

   localparam int unsigned SCORE_W = 14;
   localparam int unsigned SUM_W   = 15;
   localparam int unsigned BCD_W   = 16;
   localparam int unsigned CNT_W   = 4;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SCORE_W - 1);
   localparam logic [SUM_W-1:0] MAX_SUM  = SUM_W'(MAX_SCORE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   digits_q, digits_d;
   logic               gnt_a_q, gnt_a_d;
   logic               gnt_b_q, gnt_b_d;
   logic               bcd_valid_q, bcd_valid_d;
   logic               busy_q, busy_d;
   logic               clr_pend_q, clr_pend_d;
   logic               prio_b_q, prio_b_d;
   logic               start;

   // Add 3 to every BCD digit that is 5 or more (pre-shift correction).
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < 4; i++) begin
         if (r[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // Widened add so the sum never wraps, then clamp to the ceiling.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                  input logic [PTS_W-1:0]   p);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(s) + SUM_W'(p);
      if (sum > MAX_SUM) begin
         sum = MAX_SUM;
      end
      return SCORE_W'(sum);
   endfunction

   // Display formatting of the finished BCD value.
   function automatic logic [BCD_W-1:0] fmt_digits(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
`ifdef SCORE_SCHED_BLANK_EN
      if (b[15:12] == 4'd0) begin
         r[15:12] = 4'hF;
         if (b[11:8] == 4'd0) begin
            r[11:8] = 4'hF;
            if (b[7:4] == 4'd0) begin
               r[7:4] = 4'hF;
            end
         end
      end
`endif
      return r;
   endfunction

   // Next-state, arbitration, accumulation and conversion datapath.
   always_comb begin
      state_d     = state_q;
      score_d     = score_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      digits_d    = digits_q;
      gnt_a_d     = 1'b0;
      gnt_b_d     = 1'b0;
      bcd_valid_d = 1'b0;
      clr_pend_d  = clr_pend_q | bus.clear_score;
      prio_b_d    = prio_b_q;
      start       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (clr_pend_q || bus.clear_score) begin
               // a latched clear beats any pending request
               score_d    = '0;
               clr_pend_d = 1'b0;
               start      = 1'b1;
            end else if (bus.req_a && (!bus.req_b || !prio_b_q)) begin
               gnt_a_d  = 1'b1;
               score_d  = sat_add(score_q, bus.pts_a);
               prio_b_d = 1'b1;
               start    = 1'b1;
            end else if (bus.req_b) begin
               gnt_b_d  = 1'b1;
               score_d  = sat_add(score_q, bus.pts_b);
               prio_b_d = 1'b0;
               start    = 1'b1;
            end
         end
         CONV: begin
            {bcd_d, bin_d} = {add3(bcd_q), bin_q} << 1;
            cnt_d          = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            digits_d    = fmt_digits(bcd_q);
            bcd_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Snapshot the updated score into the converter on every grant/clear.
      if (start) begin
         state_d = CONV;
         bin_d   = score_d;
         bcd_d   = '0;
         cnt_d   = '0;
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers; clr aborts any conversion in flight.
   always_ff @(posedge segclk or posedge clr) begin
      if (clr) begin
         state_q     <= IDLE;
         score_q     <= '0;
         bin_q       <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         digits_q    <= '0;
         gnt_a_q     <= 1'b0;
         gnt_b_q     <= 1'b0;
         bcd_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         clr_pend_q  <= 1'b0;
         prio_b_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         score_q     <= score_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         digits_q    <= digits_d;
         gnt_a_q     <= gnt_a_d;
         gnt_b_q     <= gnt_b_d;
         bcd_valid_q <= bcd_valid_d;
         busy_q      <= busy_d;
         clr_pend_q  <= clr_pend_d;
         prio_b_q    <= prio_b_d;
      end
   end

   assign bus.gnt_a     = gnt_a_q;
   assign bus.gnt_b     = gnt_b_q;
   assign bus.score     = score_q;
   assign bus.digit0    = digits_q[3:0];
   assign bus.digit1    = digits_q[7:4];
   assign bus.digit2    = digits_q[11:8];
   assign bus.digit3    = digits_q[15:12];
   assign bus.bcd_valid = bcd_valid_q;
   assign bus.busy      = busy_q;

endmodule

// File: doc/score_sched.md
SCORE_SCHED -- requirements
Module: score_sched

Interface
REQ-001 The block SHALL have parameter MAX_SCORE, default 9999, saturation ceiling of the score (1..9999).
REQ-002 The block SHALL have parameter PTS_W, default 4, width of each requester's point increment.
REQ-003 Port: segclk  in  1  sole clock; all state advances on rising edge.
REQ-004 Port: clr  in  1  reset, asynchronous, active-high.
REQ-005 Port: req_a / req_b  in  1 each  score-update request; held high until the matching grant.
REQ-006 Port: pts_a / pts_b  in  PTS_W each  increment for the request; stable while its req is high.
REQ-007 Port: clear_score  in  1  single-cycle pulse requesting score := 0.
REQ-008 Port: gnt_a / gnt_b  out  1 each  one-cycle grant pulse.
REQ-009 Port: score  out  14  current binary score.
REQ-010 Port: digit0..digit3  out  4 each  BCD digits, ones..thousands, for the display driver.
REQ-011 Port: bcd_valid  out  1  one-cycle pulse when the digit outputs update.
REQ-012 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, CONV and DONE.
REQ-014 In IDLE, a pending clear (clear_score pulse latched at any time, including during CONV/DONE) SHALL take priority: score := 0, pending clear cleared, no grant, next state CONV.
REQ-015 In IDLE with no pending clear and exactly one req high, that requester SHALL be granted at that edge: gnt pulses for one cycle, score := min(score + pts, MAX_SCORE), next state CONV.
REQ-016 When req_a and req_b are both high in IDLE, the requester not granted last SHALL win (round-robin pointer; after reset, A wins); the loser remains pending.
REQ-017 Addition SHALL use a 15-bit intermediate so no wrap occurs; the result saturates at MAX_SCORE.
REQ-018 CONV SHALL perform shift-add-3 binary-to-BCD conversion on a snapshot of score, one bit per cycle, exactly 14 cycles.
REQ-019 DONE SHALL last one cycle: load digit0..digit3, pulse bcd_valid, return to IDLE.
REQ-020 Latency: grant/clear edge to bcd_valid high = 15 cycles; minimum spacing between grants = 16 cycles.
REQ-021 Requests SHALL NOT be granted outside IDLE; gnt_a and gnt_b SHALL never be high simultaneously.
REQ-022 A second clear_score pulse while a clear is already pending SHALL merge into one.

Reset
REQ-023 On clr: state IDLE, score 0, digits 0, gnt_a/gnt_b/bcd_valid/busy 0, pending clear 0, round-robin pointer favouring A.
REQ-024 clr asserted during CONV or DONE SHALL abort the conversion without any bcd_valid pulse.

Configuration
REQ-025 With macro SCORE_SCHED_BLANK_EN defined, leading-zero digits (excluding digit0) SHALL be output as 4'hF in DONE; without it, all four digits carry plain BCD including leading zeros.

Verification
REQ-026 Reset, then req_a=1, pts_a=5 for one cycle -> gnt_a pulse, score=5, bcd_valid 15 cycles later, digits 0,0,0,5 (3-0).
REQ-027 req_a and req_b held high together from reset, pts 1 and 2 -> grants alternate A,B,A,B at 16-cycle spacing; score after four grants = 6.
REQ-028 score=9995, req_b with pts_b=9 -> score=9999, digits 9,9,9,9; a further request -> score stays 9999.
REQ-029 clear_score pulsed during CONV with req_a pending -> after current DONE, clear served first (score=0, no gnt), req_a granted at the following IDLE.
REQ-030 clr asserted at cycle 7 of CONV -> no bcd_valid; all outputs 0 immediately; busy=0.
REQ-031 With SCORE_SCHED_BLANK_EN, score=42 -> digits F,F,4,2 (3-0); score=0 -> F,F,F,0.
